readout_capture: RTL and testbench

READOUT_CAPTURE -- requirements
Module: readout_capture

---
 rtl/readout_capture.sv | 167 ++++++++++++++++
 tb/tb_readout_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_capture.sv
// 2x2 pixel readout capture: ADC edge detect, row/column sequencing FSM and output FIFO.
// Optional build macro READOUT_CAPTURE_OVF_CNT_EN adds the Ovf_Count dropped-sample counter.
module readout_capture #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Erase,
    input  logic              Expose,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic              ADC,
    input  logic [DATA_W-1:0] Adc_Data,
    input  logic              Out_Ready,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Row,
    output logic              Out_Col,
    output logic              Frame_Done,
    output logic              Seq_Err
`ifdef READOUT_CAPTURE_OVF_CNT_EN
    ,
    output logic [7:0]        Ovf_Count
`endif
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = DATA_W + 2;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, ARMED, ROW1, ROW2} state_e;

    state_e               state_q, state_d;
    logic                 col_q, col_d;
    logic                 adc_q, adc_d;
    logic                 frame_done_q, frame_done_d;
    logic                 seq_err_q, seq_err_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];

    logic                 adc_rise;
    logic                 legal;
    logic                 in_row;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [ENTRY_W-1:0]   head;

    assign adc_rise = ADC & ~adc_q;
    assign in_row   = (state_q == ROW1) || (state_q == ROW2);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A capture is legal only when exactly the current row's enable is low.
    always_comb begin
        legal = 1'b0;
        if (state_q == ROW1)
            legal = adc_rise & ~NRE_1 & NRE_2;
        else if (state_q == ROW2)
            legal = adc_rise & ~NRE_2 & NRE_1;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            col_q        <= 1'b0;
            adc_q        <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            adc_q        <= adc_d;
            frame_done_q <= frame_done_d;
            seq_err_q    <= seq_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (Erase) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (Expose) state_d = ARMED;
                ARMED: if (!Expose && !NRE_1) state_d = ROW1;
                ROW1:  if (legal) begin
                           if (col_q) state_d = ROW2;
                           else       col_d   = 1'b1;
                       end
                ROW2:  if (legal) begin
                           if (col_q) state_d = IDLE;
                           else       col_d   = 1'b1;
                       end
            endcase
        end
        if (state_d != state_q)
            col_d = 1'b0;
    end

    // Output / datapath logic
    always_comb begin
        adc_d        = ADC;
        pop          = ~empty & Out_Ready;
        push         = legal & ~Erase & (~full | pop);
        drop         = legal & ~Erase & full & ~pop;
        frame_done_d = ~Erase & legal & (state_q == ROW2) & col_q;
        seq_err_d    = Erase ? in_row : ((adc_rise & ~legal) | drop);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        if (Erase) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = {(state_q == ROW2), col_q, Adc_Data};
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Head is forced to zero when empty so idle outputs read as 0.
    assign head = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign {Out_Row, Out_Col, Out_Data} = head;
    assign Out_Valid  = ~empty;
    assign Frame_Done = frame_done_q;
    assign Seq_Err    = seq_err_q;

`ifdef READOUT_CAPTURE_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && ovf_cnt_q != 8'hFF)
            ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign Ovf_Count = ovf_cnt_q;
`else
    // Dropped samples are reported only through Seq_Err in this build.
`endif

endmodule

// File: tb/tb_readout_capture.sv
// Directed self-checking bench for readout_capture (default DATA_W=8, FIFO_DEPTH=4).
module tb_readout_capture;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Erase = 1'b0;
    logic       Expose = 1'b0;
    logic       NRE_1 = 1'b1;
    logic       NRE_2 = 1'b1;
    logic       ADC = 1'b0;
    logic [7:0] Adc_Data = '0;
    logic       Out_Ready = 1'b0;
    logic       Out_Valid;
    logic [7:0] Out_Data;
    logic       Out_Row;
    logic       Out_Col;
    logic       Frame_Done;
    logic       Seq_Err;
`ifdef READOUT_CAPTURE_OVF_CNT_EN
    logic [7:0] Ovf_Count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned fd_cnt   = 0;
    int unsigned se_cnt   = 0;
    int unsigned fd_base;
    int unsigned se_base;
    logic        last_se;
    logic        last_fd;

    readout_capture #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Erase      (Erase),
        .Expose     (Expose),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .ADC        (ADC),
        .Adc_Data   (Adc_Data),
        .Out_Ready  (Out_Ready),
        .Out_Valid  (Out_Valid),
        .Out_Data   (Out_Data),
        .Out_Row    (Out_Row),
        .Out_Col    (Out_Col),
        .Frame_Done (Frame_Done),
        .Seq_Err    (Seq_Err)
`ifdef READOUT_CAPTURE_OVF_CNT_EN
        ,
        .Ovf_Count  (Ovf_Count)
`endif
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Frame_Done === 1'b1) fd_cnt++;
        if (Seq_Err === 1'b1)    se_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One ADC strobe: high for one cycle then low; records the pulses seen after the edge.
    task automatic adc_pulse(input logic [7:0] d);
        Adc_Data = d;
        ADC = 1'b1;
        tick();
        last_se = Seq_Err;
        last_fd = Frame_Done;
        ADC = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic start_frame();
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
        Expose = 1'b1;
        tick();
        Expose = 1'b0;
        NRE_1 = 1'b0;
        tick();
    endtask

    task automatic row2_sel();
        NRE_1 = 1'b1;
        NRE_2 = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        Reset = 1'b0;
        check_eq("rst_out", {Out_Valid, Out_Row, Out_Col, Out_Data, Frame_Done, Seq_Err}, 32'h0);

        // Full frame, downstream always ready
        Out_Ready = 1'b1;
        fd_base = fd_cnt;
        start_frame();
        Adc_Data = 8'h11;
        ADC = 1'b1;
        tick();
        check_eq("f1_w0", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b0, 8'h11});
        ADC = 1'b0;
        tick();
        check_eq("f1_pop", Out_Valid, 1'b0);
        Adc_Data = 8'h22;
        ADC = 1'b1;
        tick();
        check_eq("f1_w1", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b1, 8'h22});
        ADC = 1'b0;
        tick();
        row2_sel();
        Adc_Data = 8'h33;
        ADC = 1'b1;
        tick();
        check_eq("f1_w2", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b1, 1'b0, 8'h33});
        ADC = 1'b0;
        tick();
        Adc_Data = 8'h44;
        ADC = 1'b1;
        tick();
        check_eq("f1_w3", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b1, 1'b1, 8'h44});
        check_eq("f1_done", Frame_Done, 1'b1);
        ADC = 1'b0;
        tick();
        check_eq("f1_done_1cyc", Frame_Done, 1'b0);
        check_eq("f1_done_cnt", fd_cnt - fd_base, 1);

        // Same frame with downstream stalled: four words held, no error
        Out_Ready = 1'b0;
        se_base = se_cnt;
        start_frame();
        adc_pulse(8'h11);
        adc_pulse(8'h22);
        row2_sel();
        adc_pulse(8'h33);
        adc_pulse(8'h44);
        tick();
        check_eq("full_head", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b0, 8'h11});
        check_eq("full_no_err", se_cnt - se_base, 0);

        // Fifth edge on a full FIFO without pop: dropped, Seq_Err
        start_frame();
        adc_pulse(8'h55);
        check_eq("ovf_err", last_se, 1'b1);
        check_eq("ovf_head", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b0, 8'h11});
`ifdef READOUT_CAPTURE_OVF_CNT_EN
        check_eq("ovf_cnt", Ovf_Count, 8'd1);
`endif

        // Push on full with simultaneous pop succeeds (column advanced to 1 by the drop)
        Adc_Data = 8'h66;
        ADC = 1'b1;
        Out_Ready = 1'b1;
        tick();
        check_eq("pp_no_err", Seq_Err, 1'b0);
        ADC = 1'b0;
        Out_Ready = 1'b0;
        tick();
        check_eq("pp_h0", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b1, 8'h22});
        Out_Ready = 1'b1;
        tick();
        check_eq("pp_h1", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b1, 1'b0, 8'h33});
        tick();
        check_eq("pp_h2", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b1, 1'b1, 8'h44});
        tick();
        check_eq("pp_h3", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b1, 8'h66});
        tick();
        check_eq("pp_empty", {Out_Valid, Out_Row, Out_Col, Out_Data}, 32'h0);

        // Both enables low in ROW1: error, no push, column stays 0
        do_reset();
        Out_Ready = 1'b0;
        start_frame();
        NRE_2 = 1'b0;
        adc_pulse(8'hAA);
        check_eq("both_err", last_se, 1'b1);
        check_eq("both_nopush", Out_Valid, 1'b0);
        NRE_2 = 1'b1;
        adc_pulse(8'hBB);
        check_eq("both_col0", {Out_Valid, Out_Row, Out_Col, Out_Data}, {1'b1, 1'b0, 1'b0, 8'hBB});

        // Edge in IDLE is a protocol error
        do_reset();
        NRE_1 = 1'b0;
        adc_pulse(8'h77);
        check_eq("idle_err", last_se, 1'b1);
        check_eq("idle_nopush", Out_Valid, 1'b0);

        // Erase during ROW1 flushes and returns to IDLE
        do_reset();
        start_frame();
        adc_pulse(8'h11);
        check_eq("er_pre", {Out_Valid, Out_Data}, {1'b1, 8'h11});
        Erase = 1'b1;
        tick();
        check_eq("er_flush", Out_Valid, 1'b0);
        check_eq("er_err", Seq_Err, 1'b1);
        Erase = 1'b0;
        tick();
        check_eq("er_err_1cyc", Seq_Err, 1'b0);
        adc_pulse(8'h99);
        check_eq("er_idle", {last_se, Out_Valid}, {1'b1, 1'b0});

        // Reset during ROW2 with three words queued
        do_reset();
        fd_base = fd_cnt;
        start_frame();
        adc_pulse(8'h11);
        adc_pulse(8'h22);
        row2_sel();
        adc_pulse(8'h33);
        check_eq("rr_pre", {Out_Valid, Out_Data}, {1'b1, 8'h11});
        Reset = 1'b1;
        tick();
        check_eq("rr_out", {Out_Valid, Out_Row, Out_Col, Out_Data, Frame_Done, Seq_Err}, 32'h0);
        Reset = 1'b0;
        adc_pulse(8'h44);
        check_eq("rr_discard", {last_fd, last_se, Out_Valid}, {1'b0, 1'b1, 1'b0});
        check_eq("rr_no_done", fd_cnt - fd_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got sim time limit expected $finish");
        $fatal(1);
    end

endmodule
